// File: rtl/oscope_pkg.sv
// oscope_pkg: shared capture FSM states and default frame geometry for the scope ADC front end.
package oscope_pkg;
    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} adc_state_t;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_SAMPLE_W = 8;
    localparam int DEF_MSB_POS = 13;
endpackage

// File: rtl/clk_div_strobe.sv
// clk_div_strobe: programmable half-period divider producing adc_clk and registered edge strobes.
module clk_div_strobe #(
    parameter int DIV_W = 24
) (
    input  logic             osc_clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] half_div,
    output logic             adc_clk,
    output logic             rise,
    output logic             fall
);
    logic [DIV_W-1:0] cnt_q, cnt_d, half_eff;
    logic clk_q, clk_d, rise_q, rise_d, fall_q, fall_d, tc;
    // >= rather than == so a shrinking half_div still wraps instead of running to full scale
    always_comb begin
        half_eff = (half_div == '0) ? DIV_W'(1) : half_div;
        tc = enable && (cnt_q >= half_eff - DIV_W'(1));
        cnt_d = (!enable || tc) ? '0 : cnt_q + DIV_W'(1);
        clk_d = enable && (tc ? !clk_q : clk_q);
        rise_d = tc && !clk_q;
        fall_d = tc && clk_q;
    end
    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
    assign adc_clk = clk_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/adc_stream_capture.sv
// adc_stream_capture: serial ADC frame capture with field extraction, decimation and a
// single-entry valid/ready output stage that flags dropped samples.
module adc_stream_capture
    import oscope_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int MSB_POS = DEF_MSB_POS,
    parameter int DIV_W = 24,
    parameter int DEC_W = 8
) (
    input  logic                osc_clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [DIV_W-1:0]    half_div,
    input  logic [DEC_W-1:0]    decim,
    input  logic                clr_ovr,
    input  logic                adc_data,
    output logic                adc_clk,
    output logic                adc_conv,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    output logic                busy
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    if (MSB_POS >= FRAME_BITS || MSB_POS < SAMPLE_W - 1) begin : g_bad_msb_pos
        $error("adc_stream_capture: MSB_POS must lie in [SAMPLE_W-1, FRAME_BITS-1]");
    end

    adc_state_t state_q, state_d;
    logic conv_q, conv_d, valid_q, valid_d, ovr_q, ovr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic keep, load, div_en, div_rise, div_fall, unused_bits;

    // Divider stops in IDLE and is already cleared on the cycle the FSM falls back to IDLE
    assign div_en = (state_q != IDLE) && (state_d != IDLE);

    clk_div_strobe #(.DIV_W(DIV_W)) u_div (
        .osc_clk  (osc_clk),
        .reset_n  (reset_n),
        .enable   (div_en),
        .half_div (half_div),
        .adc_clk  (adc_clk),
        .rise     (div_rise),
        .fall     (div_fall)
    );

    always_comb begin
        state_d = state_q;
        conv_d = conv_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d = sreg_q;
        dec_cnt_d = dec_cnt_q;
        keep = 1'b0;
        case (state_q)
            IDLE: begin
                conv_d = 1'b1;
                state_d = run ? CONV : IDLE;
            end
            CONV: if (div_rise) begin
                conv_d = 1'b0;
                bit_cnt_d = '0;
                state_d = SHIFT;
            end
            SHIFT: if (div_rise) begin
                sreg_d = {sreg_q[FRAME_BITS-2:0], adc_data};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                    conv_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                keep = (dec_cnt_q == '0);
                dec_cnt_d = (dec_cnt_q == decim) ? '0 : dec_cnt_q + DEC_W'(1);
                state_d = run ? CONV : IDLE;
            end
            default: state_d = IDLE;
        endcase
        load = keep && (!valid_q || sample_ready);
        data_d = load ? sreg_q[MSB_POS -: SAMPLE_W] : data_q;
        valid_d = load || (valid_q && !sample_ready);
        ovr_d = (keep && !load) || (ovr_q && !clr_ovr);
    end

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            conv_q <= 1'b1;
            bit_cnt_q <= '0;
            sreg_q <= '0;
            dec_cnt_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            conv_q <= conv_d;
            bit_cnt_q <= bit_cnt_d;
            sreg_q <= sreg_d;
            dec_cnt_q <= dec_cnt_d;
            data_q <= data_d;
            valid_q <= valid_d;
            ovr_q <= ovr_d;
        end
    end

    assign unused_bits = ^{sreg_q, div_fall};
    assign adc_conv = conv_q;
    assign sample_data = data_q;
    assign sample_valid = valid_q;
    assign overrun = ovr_q;
    assign busy = (state_q != IDLE);
endmodule
